starflux_datapath_n: RTL and testbench

- Parametrised successor to the single-enemy game datapath.
- Generalises to N enemies in a marching formation, a fixed pool of independently tracked bullets, per-enemy alive state, a score counter and wave respawn.
- Replaces the full-screen bit grid with a compact bullet slot table.
- Sits between the control FSM, which supplies the enable strobes, and the VGA drawing logic, which consumes positions.

---
 rtl/starflux_datapath_n_if.sv | 34 +++
 rtl/starflux_datapath_n.sv | 235 +++++++++++++++++++++++
 tb/tb_starflux_datapath_n.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/starflux_datapath_n_if.sv
// Bus bundle between the game control/VGA side and the starflux datapath.
// The master side drives the movement/fire requests and tick strobes. The
// slave side (the datapath) returns positions, the alive mask and the score.
interface starflux_datapath_n_if #(
   parameter int NUM_ENEMIES = 4,
   parameter int MAX_BULLETS = 4
) ();
   logic                       left;
   logic                       right;
   logic                       shoot;
   logic                       ship_update_en;
   logic                       grid_update_en;
   logic [7:0]                 user_x;
   logic [8*NUM_ENEMIES-1:0]   enemy_x;
   logic [NUM_ENEMIES-1:0]     enemy_alive;
   logic [3:0]                 gun_cooldown;
   logic [MAX_BULLETS-1:0]     bullet_valid;
   logic [8*MAX_BULLETS-1:0]   bullet_x;
   logic [8*MAX_BULLETS-1:0]   bullet_y;
   logic [15:0]                score;
   logic                       wave_clear;

   modport master (
      output left, right, shoot, ship_update_en, grid_update_en,
      input  user_x, enemy_x, enemy_alive, gun_cooldown, bullet_valid,
             bullet_x, bullet_y, score, wave_clear
   );

   modport slave (
      input  left, right, shoot, ship_update_en, grid_update_en,
      output user_x, enemy_x, enemy_alive, gun_cooldown, bullet_valid,
             bullet_x, bullet_y, score, wave_clear
   );
endinterface

// File: rtl/starflux_datapath_n.sv
// Starflux game datapath: ship, marching N-enemy formation, bullet slot
// table, score counter and wave respawn. All state is held in registers and
// every strobe-driven update becomes visible on the cycle after the strobe.
module starflux_datapath_n #(
   parameter int SCREEN_W      = 160,
   parameter int SCREEN_H      = 120,
   parameter int SHIP_W        = 8,
   parameter int SHIP_Y        = 112,
   parameter int NUM_ENEMIES   = 4,
   parameter int ENEMY_W       = 8,
   parameter int ENEMY_SPACING = 16,
   parameter int ENEMY_Y       = 8,
   parameter int MAX_BULLETS   = 4,
   parameter int COOLDOWN      = 4,
   parameter int ENEMY_DIV     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   starflux_datapath_n_if.slave  bus
);
   // Bullets spawn one row above the ship; keep that row inside the playfield.
   localparam logic [7:0] LP_SPAWN_Y  = 8'((SHIP_Y - 1 < SCREEN_H) ? SHIP_Y - 1 : SCREEN_H - 1);
   localparam logic [7:0] LP_USER_X0  = 8'(SCREEN_W / 2);
   localparam logic [7:0] LP_USER_MAX = 8'(SCREEN_W - SHIP_W);
   localparam logic [7:0] LP_GUN_OFS  = 8'(SHIP_W / 2);
   localparam logic [3:0] LP_COOLDOWN = 4'(COOLDOWN);
   localparam logic [7:0] LP_ENEMY_Y  = 8'(ENEMY_Y);
   localparam logic [8:0] LP_ENEMY_W  = 9'(ENEMY_W);
   localparam logic [8:0] LP_SCREEN_W = 9'(SCREEN_W);
   localparam logic [7:0] LP_DIV_LAST = 8'(ENEMY_DIV - 1);

   typedef enum logic {ST_PLAY = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t                 r_state, w_state_next;
   logic                   w_wave_clear;

   logic [7:0]             r_user_x, w_user_x_next;
   logic [7:0]             r_enemy_x [NUM_ENEMIES];
   logic [7:0]             w_enemy_x_next [NUM_ENEMIES];
   logic [NUM_ENEMIES-1:0] r_alive, w_alive_next;
   logic                   r_dir_left, w_dir_left_next;
   logic [7:0]             r_div, w_div_next;
   logic [3:0]             r_cooldown, w_cooldown_next;
   logic [MAX_BULLETS-1:0] r_bvalid, w_bvalid_next;
   logic [7:0]             r_bx [MAX_BULLETS];
   logic [7:0]             w_bx_next [MAX_BULLETS];
   logic [7:0]             r_by [MAX_BULLETS];
   logic [7:0]             w_by_next [MAX_BULLETS];
   logic [15:0]            r_score, w_score_next;
   logic                   r_shoot_prev;

   logic [NUM_ENEMIES-1:0] w_kill;
   logic [3:0]             w_kill_cnt;
   logic [16:0]            w_score_sum;
   logic [MAX_BULLETS-1:0] w_fire_sel;
   logic                   w_slot_taken;
   logic                   w_fire_ok;

   // State register for the PLAY/CLEAR wave sequencer.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_PLAY;
      else       r_state <= w_state_next;
   end

   // Next state: enter CLEAR once the whole formation is dead, leave after one cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_PLAY:  if (r_alive == '0) w_state_next = ST_CLEAR;
         ST_CLEAR: w_state_next = ST_PLAY;
         default:  w_state_next = ST_PLAY;
      endcase
   end

   // Output decode: wave_clear is high for the single CLEAR cycle.
   always_comb begin
      w_wave_clear = (r_state == ST_CLEAR);
   end

   // Next-value datapath: ship, cooldown, bullets, collisions, formation, fire.
   always_comb begin
      w_user_x_next   = r_user_x;
      w_alive_next    = r_alive;
      w_dir_left_next = r_dir_left;
      w_div_next      = r_div;
      w_cooldown_next = r_cooldown;
      w_bvalid_next   = r_bvalid;
      w_score_next    = r_score;
      w_kill          = '0;
      w_kill_cnt      = '0;
      w_score_sum     = '0;
      w_fire_sel      = '0;
      w_slot_taken    = 1'b0;
      w_fire_ok       = 1'b0;
      for (int e = 0; e < NUM_ENEMIES; e++) w_enemy_x_next[e] = r_enemy_x[e];
      for (int b = 0; b < MAX_BULLETS; b++) begin
         w_bx_next[b] = r_bx[b];
         w_by_next[b] = r_by[b];
      end

      if (r_state == ST_CLEAR) begin
         // Respawn the wave; score, ship position and cooldown carry over.
         w_alive_next    = '1;
         w_dir_left_next = 1'b0;
         w_div_next      = '0;
         w_bvalid_next   = '0;
         for (int e = 0; e < NUM_ENEMIES; e++) w_enemy_x_next[e] = 8'(e * ENEMY_SPACING);
      end else begin
         if (bus.ship_update_en) begin
            if (bus.left && !bus.right && r_user_x != 8'd0)
               w_user_x_next = r_user_x - 8'd1;
            else if (bus.right && !bus.left && r_user_x < LP_USER_MAX)
               w_user_x_next = r_user_x + 8'd1;
            if (r_cooldown != 4'd0)
               w_cooldown_next = r_cooldown - 4'd1;
         end

         if (bus.grid_update_en) begin
            // Bullets step up one row; collisions use the pre-step formation.
            for (int b = 0; b < MAX_BULLETS; b++) begin
               if (r_bvalid[b]) begin
                  if (r_by[b] == 8'd0) begin
                     w_bvalid_next[b] = 1'b0;
                  end else begin
                     w_by_next[b] = r_by[b] - 8'd1;
                     for (int e = 0; e < NUM_ENEMIES; e++) begin
                        if (r_alive[e] && w_by_next[b] == LP_ENEMY_Y &&
                            r_bx[b] >= r_enemy_x[e] &&
                            {1'b0, r_bx[b]} < {1'b0, r_enemy_x[e]} + LP_ENEMY_W) begin
                           w_bvalid_next[b] = 1'b0;
                           w_kill[e]        = 1'b1;
                        end
                     end
                  end
               end
            end
            // An enemy hit by several bullets in one tick scores once.
            for (int e = 0; e < NUM_ENEMIES; e++) w_kill_cnt = w_kill_cnt + 4'(w_kill[e]);
            w_alive_next = r_alive & ~w_kill;
            w_score_sum  = {1'b0, r_score} + 17'(w_kill_cnt);
            w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

            // Formation advances once every ENEMY_DIV grid ticks; hitting a
            // wall spends that step turning around instead of moving.
            if (r_div == LP_DIV_LAST) begin
               w_div_next = '0;
               if (!r_dir_left) begin
                  if ({1'b0, r_enemy_x[NUM_ENEMIES-1]} + LP_ENEMY_W == LP_SCREEN_W)
                     w_dir_left_next = 1'b1;
                  else
                     for (int e = 0; e < NUM_ENEMIES; e++) w_enemy_x_next[e] = r_enemy_x[e] + 8'd1;
               end else begin
                  if (r_enemy_x[0] == 8'd0)
                     w_dir_left_next = 1'b0;
                  else
                     for (int e = 0; e < NUM_ENEMIES; e++) w_enemy_x_next[e] = r_enemy_x[e] - 8'd1;
               end
            end else begin
               w_div_next = r_div + 8'd1;
            end
         end

         // Fire on a rising shoot edge into the lowest free slot. The slot was
         // free before this cycle, so the grid step above never touched it.
         for (int b = 0; b < MAX_BULLETS; b++) begin
            if (!r_bvalid[b] && !w_slot_taken) begin
               w_fire_sel[b] = 1'b1;
               w_slot_taken  = 1'b1;
            end
         end
         w_fire_ok = bus.shoot && !r_shoot_prev && (r_cooldown == 4'd0) && w_slot_taken;
         if (w_fire_ok) begin
            w_cooldown_next = LP_COOLDOWN;
            for (int b = 0; b < MAX_BULLETS; b++) begin
               if (w_fire_sel[b]) begin
                  w_bvalid_next[b] = 1'b1;
                  w_bx_next[b]     = r_user_x + LP_GUN_OFS;
                  w_by_next[b]     = LP_SPAWN_Y;
               end
            end
         end
      end
   end

   // Datapath registers with synchronous reset to the start-of-game layout.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_user_x     <= LP_USER_X0;
         r_alive      <= '1;
         r_dir_left   <= 1'b0;
         r_div        <= '0;
         r_cooldown   <= '0;
         r_bvalid     <= '0;
         r_score      <= '0;
         r_shoot_prev <= 1'b0;
         for (int e = 0; e < NUM_ENEMIES; e++) r_enemy_x[e] <= 8'(e * ENEMY_SPACING);
         for (int b = 0; b < MAX_BULLETS; b++) begin
            r_bx[b] <= '0;
            r_by[b] <= '0;
         end
      end else begin
         r_user_x     <= w_user_x_next;
         r_alive      <= w_alive_next;
         r_dir_left   <= w_dir_left_next;
         r_div        <= w_div_next;
         r_cooldown   <= w_cooldown_next;
         r_bvalid     <= w_bvalid_next;
         r_score      <= w_score_next;
         r_shoot_prev <= bus.shoot;
         for (int e = 0; e < NUM_ENEMIES; e++) r_enemy_x[e] <= w_enemy_x_next[e];
         for (int b = 0; b < MAX_BULLETS; b++) begin
            r_bx[b] <= w_bx_next[b];
            r_by[b] <= w_by_next[b];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ENEMIES; gi++) begin : g_enemy_out
         assign bus.enemy_x[8*gi +: 8] = r_enemy_x[gi];
      end
      for (gi = 0; gi < MAX_BULLETS; gi++) begin : g_bullet_out
         assign bus.bullet_x[8*gi +: 8] = r_bx[gi];
         assign bus.bullet_y[8*gi +: 8] = r_by[gi];
      end
   endgenerate

   assign bus.user_x       = r_user_x;
   assign bus.enemy_alive  = r_alive;
   assign bus.gun_cooldown = r_cooldown;
   assign bus.bullet_valid = r_bvalid;
   assign bus.score        = r_score;
   assign bus.wave_clear   = w_wave_clear;
endmodule

// File: tb/tb_starflux_datapath_n.sv
// Directed bench for starflux_datapath_n. Two instances share one stimulus:
// A uses the default parameters, B uses ENEMY_DIV=200 so its formation stays
// parked during the long bullet-flight scenarios.
module tb_starflux_datapath_n;
   logic clk = 1'b0;
   logic reset;
   logic left, right, shoot, ship_en, grid_en;

   always #5 clk = ~clk;

   starflux_datapath_n_if #(.NUM_ENEMIES(4), .MAX_BULLETS(4)) bus_a ();
   starflux_datapath_n_if #(.NUM_ENEMIES(4), .MAX_BULLETS(4)) bus_b ();

   assign bus_a.left = left;             assign bus_b.left = left;
   assign bus_a.right = right;           assign bus_b.right = right;
   assign bus_a.shoot = shoot;           assign bus_b.shoot = shoot;
   assign bus_a.ship_update_en = ship_en; assign bus_b.ship_update_en = ship_en;
   assign bus_a.grid_update_en = grid_en; assign bus_b.grid_update_en = grid_en;

   starflux_datapath_n u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   starflux_datapath_n #(.ENEMY_DIV(200)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   localparam int F_UX = 0, F_EX = 1, F_AL = 2, F_CD = 3, F_BV = 4,
                  F_BX = 5, F_BY = 6, F_SC = 7, F_WC = 8;

   typedef struct {
      string       tag;
      bit          dut_b;
      int          field;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] obs(bit dut_b, int field);
      logic [31:0] v;
      v = '0;
      case (field)
         F_UX: v = dut_b ? 32'(bus_b.user_x)       : 32'(bus_a.user_x);
         F_EX: v = dut_b ? bus_b.enemy_x           : bus_a.enemy_x;
         F_AL: v = dut_b ? 32'(bus_b.enemy_alive)  : 32'(bus_a.enemy_alive);
         F_CD: v = dut_b ? 32'(bus_b.gun_cooldown) : 32'(bus_a.gun_cooldown);
         F_BV: v = dut_b ? 32'(bus_b.bullet_valid) : 32'(bus_a.bullet_valid);
         F_BX: v = dut_b ? bus_b.bullet_x          : bus_a.bullet_x;
         F_BY: v = dut_b ? bus_b.bullet_y          : bus_a.bullet_y;
         F_SC: v = dut_b ? 32'(bus_b.score)        : 32'(bus_a.score);
         F_WC: v = dut_b ? 32'(bus_b.wave_clear)   : 32'(bus_a.wave_clear);
         default: v = 'x;
      endcase
      return v;
   endfunction

   task automatic expect_val(input string tag, input bit dut_b, input int field, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.dut_b = dut_b; e.field = field; e.exp = v;
      exp_q.push_back(e);
   endtask

   task automatic check_pending();
      exp_t        e;
      logic [31:0] o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs(e.dut_b, e.field);
         checks++;
         assert (o === e.exp)
            $display("check %s: observed=%0h expected=%0h ok", e.tag, o, e.exp);
         else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, o, e.exp);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      check_pending();
   endtask

   task automatic expect_reset(input string tag, input bit dut_b);
      expect_val({tag, "_ux"}, dut_b, F_UX, 32'd80);
      expect_val({tag, "_ex"}, dut_b, F_EX, 32'h30201000);
      expect_val({tag, "_al"}, dut_b, F_AL, 32'hF);
      expect_val({tag, "_cd"}, dut_b, F_CD, 32'd0);
      expect_val({tag, "_bv"}, dut_b, F_BV, 32'd0);
      expect_val({tag, "_bx"}, dut_b, F_BX, 32'd0);
      expect_val({tag, "_by"}, dut_b, F_BY, 32'd0);
      expect_val({tag, "_sc"}, dut_b, F_SC, 32'd0);
      expect_val({tag, "_wc"}, dut_b, F_WC, 32'd0);
   endtask

   initial begin
      reset = 1'b1; left = 0; right = 0; shoot = 0; ship_en = 0; grid_en = 0;
      #2;
      // Reset state on both instances
      expect_reset("rst_a", 1'b0);
      expect_reset("rst_b", 1'b1);
      cyc();
      reset = 1'b0;

      // Ship climbs to the right wall and holds
      right = 1; ship_en = 1;
      expect_val("ship_r1", 1'b0, F_UX, 32'd81);
      cyc();
      repeat (98) cyc();
      expect_val("ship_rmax", 1'b0, F_UX, 32'd152);
      expect_val("ship_rmax_b", 1'b1, F_UX, 32'd152);
      cyc();
      left = 1;
      expect_val("ship_both", 1'b0, F_UX, 32'd152);
      cyc();
      left = 0; right = 0; ship_en = 0;

      // First shot and cooldown
      reset = 1; cyc(); reset = 0;
      shoot = 1;
      expect_val("fire_bv", 1'b0, F_BV, 32'h1);
      expect_val("fire_bx", 1'b0, F_BX, 32'h00000054);
      expect_val("fire_by", 1'b0, F_BY, 32'h0000006F);
      expect_val("fire_cd", 1'b0, F_CD, 32'd4);
      cyc();
      shoot = 0; cyc();
      shoot = 1;
      expect_val("refire_bv", 1'b0, F_BV, 32'h1);
      expect_val("refire_cd", 1'b0, F_CD, 32'd4);
      cyc();
      shoot = 0; ship_en = 1;
      expect_val("cd_dec", 1'b0, F_CD, 32'd3);
      cyc();
      repeat (2) cyc();
      expect_val("cd_zero", 1'b0, F_CD, 32'd0);
      cyc();
      ship_en = 0;

      // Fill every slot, then a fifth shot finds no room
      for (int k = 2; k <= 4; k++) begin
         shoot = 1;
         expect_val("fill_bv", 1'b0, F_BV, 32'((1 << k) - 1));
         cyc();
         shoot = 0; ship_en = 1;
         repeat (4) cyc();
         ship_en = 0;
      end
      expect_val("fill_bx", 1'b0, F_BX, 32'h54545454);
      shoot = 1;
      expect_val("full_bv", 1'b0, F_BV, 32'hF);
      expect_val("full_cd", 1'b0, F_CD, 32'd0);
      cyc();
      shoot = 0;

      // Reset mid-play
      right = 1; ship_en = 1; repeat (2) cyc(); right = 0; ship_en = 0;
      reset = 1;
      expect_reset("midrst", 1'b0);
      cyc();
      reset = 0;

      // Two bullets at x=4 hit enemy 0 together on instance B
      left = 1; ship_en = 1; repeat (80) cyc(); left = 0; ship_en = 0;
      shoot = 1; cyc(); shoot = 0;
      ship_en = 1; repeat (4) cyc(); ship_en = 0;
      shoot = 1;
      expect_val("twin_bv", 1'b1, F_BV, 32'h3);
      expect_val("twin_bx", 1'b1, F_BX, 32'h00000404);
      cyc();
      shoot = 0; grid_en = 1;
      repeat (101) cyc();
      expect_val("flight_by", 1'b1, F_BY, 32'h00000909);
      expect_val("flight_al", 1'b1, F_AL, 32'hF);
      cyc();
      expect_val("hit_al", 1'b1, F_AL, 32'hE);
      expect_val("hit_bv", 1'b1, F_BV, 32'h0);
      expect_val("hit_sc", 1'b1, F_SC, 32'd1);
      cyc();
      grid_en = 0;

      // Four bullets wipe out the wave in one tick on instance B
      reset = 1; cyc(); reset = 0;
      left = 1; ship_en = 1; repeat (80) cyc(); left = 0; ship_en = 0;
      for (int k = 0; k < 4; k++) begin
         shoot = 1; cyc(); shoot = 0;
         right = 1; ship_en = 1; repeat (16) cyc(); right = 0; ship_en = 0;
      end
      expect_val("wave_bv", 1'b1, F_BV, 32'hF);
      expect_val("wave_bx", 1'b1, F_BX, 32'h34241404);
      cyc();
      grid_en = 1;
      repeat (102) cyc();
      expect_val("wipe_al", 1'b1, F_AL, 32'h0);
      expect_val("wipe_sc", 1'b1, F_SC, 32'd4);
      expect_val("wipe_wc", 1'b1, F_WC, 32'd0);
      cyc();
      grid_en = 0;
      expect_val("clear_wc", 1'b1, F_WC, 32'd1);
      expect_val("clear_al", 1'b1, F_AL, 32'h0);
      cyc();
      expect_val("respawn_wc", 1'b1, F_WC, 32'd0);
      expect_val("respawn_al", 1'b1, F_AL, 32'hF);
      expect_val("respawn_ex", 1'b1, F_EX, 32'h30201000);
      expect_val("respawn_sc", 1'b1, F_SC, 32'd4);
      expect_val("respawn_bv", 1'b1, F_BV, 32'h0);
      expect_val("respawn_ux", 1'b1, F_UX, 32'd64);
      cyc();

      // Formation marches to the right wall and turns on instance A
      reset = 1; cyc(); reset = 0;
      grid_en = 1;
      repeat (206) cyc();
      expect_val("march_207", 1'b0, F_EX, 32'h97877767);
      cyc();
      expect_val("march_208", 1'b0, F_EX, 32'h98887868);
      cyc();
      cyc();
      expect_val("turn_210", 1'b0, F_EX, 32'h98887868);
      cyc();
      cyc();
      expect_val("back_212", 1'b0, F_EX, 32'h97877767);
      cyc();
      grid_en = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
